instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] SHALL be 00.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: word driven on instr whenever instr_valid=0 (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_addr  output  32  byte address of requested word (= pc).
REQ-008 imem_rsp_valid  input  1  response word present this cycle.
REQ-009 imem_rsp_data  input  32  fetched instruction word.
REQ-010 instr  output  32  instruction presented to decode/control.
REQ-011 instr_valid  output  1  instr and pc are valid.
REQ-012 instr_ready  input  1  downstream retires the presented instruction this cycle.
REQ-013 pc  output  32  address of presented instruction.
REQ-014 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-015 PCSRC  input  1  branch taken for presented instruction; sampled only on retire.
REQ-016 imm_ext  input  32  sign-extended branch offset; sampled only on retire.

Function
REQ-017 FSM SHALL have three states: S_REQ, S_WAIT, S_HOLD; one outstanding request maximum.
REQ-018 S_REQ: imem_req_valid=1, imem_addr=pc; imem_req_valid=1 AND imem_req_ready=1 -> S_WAIT; else remain.
REQ-019 S_WAIT: imem_req_valid=0; imem_rsp_valid=1 -> capture imem_rsp_data into instr register, -> S_HOLD; else remain, no timeout.
REQ-020 S_HOLD: instr_valid=1, instr=captured word; instr and pc SHALL stay stable until retire.
REQ-021 Retire = S_HOLD AND instr_ready=1; on retire pc <= PCSRC ? pc + imm_ext : pc + 4, state -> S_REQ.
REQ-022 Branch target bits [1:0] SHALL be forced to 00 before loading pc.
REQ-023 All PC arithmetic 32-bit, wrap modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000), no overflow flag.
REQ-024 instr_valid=0 in S_REQ and S_WAIT, and instr SHALL equal NOP_INSTR there.
REQ-025 imem_rsp_valid while in S_REQ or S_HOLD SHALL be ignored, no state change.
REQ-026 PCSRC and imm_ext SHALL be ignored outside retire cycle.
REQ-027 Minimum fetch-to-present latency: request accept at cycle N, response at N+1, instr_valid=1 at N+2; back-to-back retire throughput one instruction per 3 cycles when memory is zero-wait.
REQ-028 pc_plus4 SHALL be combinational from pc, valid in every state.

Reset
REQ-029 areset=1 at a clock edge SHALL set pc=RESET_PC, state=S_REQ, instr register=NOP_INSTR, instr_valid=0, imem_req_valid=1 the following cycle.
REQ-030 Reset in any state, including S_WAIT with a response in flight, SHALL abandon that fetch; instruction memory shares areset and discards its pending response.
REQ-031 areset SHALL take priority over retire, request accept and response capture in the same cycle.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the FSM state encoding (2 bits), RESET_PC default, NOP_INSTR and the PC width constant (32).
REQ-033 Next-PC arithmetic (pc+4, pc+imm_ext, alignment mask, select) SHALL be one combinational sub-module pc_next_calc; FSM and registers stay in instr_fetch_unit.

Verification
REQ-034 Reset, memory always ready, rsp one cycle after req -> first request addr 0x0; instr_valid=1 two cycles after accept; pc=0x0.
REQ-035 Retire with PCSRC=0 at pc=0x10 -> next imem_addr 0x14; PCSRC=1, imm_ext=0xFFFF_FFF8 at pc=0x10 -> next imem_addr 0x08.
REQ-036 Hold instr_ready=0 for 5 cycles in S_HOLD, toggle PCSRC/imm_ext -> instr, pc unchanged; no new request issued.
REQ-037 imem_req_ready=0 for 3 cycles, then 1 -> imem_addr stable throughout; exactly one accept; spurious imem_rsp_valid in S_REQ ignored.
REQ-038 pc=0xFFFF_FFFC, retire with PCSRC=0 -> next pc 0x0000_0000; PCSRC=1, imm_ext=0x6 at pc=0x100 -> pc 0x104 (bits[1:0] cleared).
REQ-039 Assert areset in S_WAIT -> next cycle state S_REQ, imem_addr=RESET_PC, instr=0x0000_0013, instr_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
// Also holds the word-alignment constants used by the next-PC datapath.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam logic [PC_W-1:0] PC_STEP    = 32'd4;
    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory port and the decode-side port of the fetch unit.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // a response is a single-cycle imem_rsp_valid pulse (no backpressure); an instruction
    // retires on a cycle where instr_valid && instr_ready. A valid output is never dropped
    // or changed before its transfer cycle.
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic               PCSRC;
    logic [PC_W-1:0]    imm_ext;

    modport master (
        output imem_req_valid, imem_addr, instr, instr_valid, pc, pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, PCSRC, imm_ext
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr, instr_valid, pc, pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, PCSRC, imm_ext
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC datapath: sequential step or word-aligned branch target.
// All arithmetic wraps modulo 2^32.
module pc_next_calc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] imm_ext_i,
    input  logic            pcsrc_i,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic [PC_W-1:0] pc_next_o
);

    logic [PC_W-1:0] target;

    assign pc_plus4_o = pc_i + PC_STEP;
    // Odd offsets would produce a misaligned fetch; clear the byte-offset bits.
    assign target     = (pc_i + imm_ext_i) & ALIGN_MASK;
    assign pc_next_o  = pcsrc_i ? target : pc_plus4_o;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for the word, hold it until retire.
// The FSM state is exported on state_o for observation.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               areset,
    instr_fetch_unit_if.master bus,
    output fetch_state_e       state_o
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_plus4;
    logic [PC_W-1:0]    pc_next;
    logic               retire;

    assign retire = (state_q == S_HOLD) && bus.instr_ready;

    pc_next_calc u_pc_next_calc (
        .pc_i       (pc_q),
        .imm_ext_i  (bus.imm_ext),
        .pcsrc_i    (bus.PCSRC),
        .pc_plus4_o (pc_plus4),
        .pc_next_o  (pc_next)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC & ALIGN_MASK;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Responses outside S_WAIT and branch inputs outside a retire are simply not looked at.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            S_REQ: begin
                if (bus.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d = bus.imem_rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d    = pc_next;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.instr_valid    = 1'b0;
        bus.instr          = NOP_INSTR;
        unique case (state_q)
            S_REQ:   bus.imem_req_valid = 1'b1;
            S_HOLD: begin
                bus.instr_valid = 1'b1;
                bus.instr       = instr_q;
            end
            default: ;
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign state_o       = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory/decode driver feeds a PC reference model,
// and a negedge monitor checks fetch addresses and presented instructions against queues.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic        pcsrc;
        logic [31:0] imm;
        logic [31:0] exp_next;
    } dir_t;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    fetch_state_e state;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk     (clk),
        .areset  (areset),
        .bus     (bus.master),
        .state_o (state)
    );

    always #5 clk = ~clk;

    // Scoreboard queues: expected fetch addresses, and expected {pc, instr} presentations.
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_q[$];
    dir_t        dir_q[$];

    int n_vec = 0;
    int n_err = 0;

    logic mon_en = 1'b0;
    logic rsp_real = 1'b0;
    logic exp_valid_next = 1'b0;

    // Reference model state
    logic [31:0] model_pc;
    logic        pending, holding, acc_seen, ret_seen, ret_pcsrc;
    logic [31:0] ret_imm;
    int          rsp_wait, hold_cycles, n_retired;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_valid_next) chk("latency_valid", {31'd0, bus.instr_valid}, 32'd1);
            exp_valid_next = rsp_real;
            if (bus.imem_req_valid) begin
                chk("no_req_while_valid", {31'd0, bus.instr_valid}, 32'd0);
                if (exp_addr_q.size() == 0) chk("addr_q_nonempty", 32'd0, 32'd1);
                else begin
                    chk("imem_addr", bus.imem_addr, exp_addr_q[0]);
                    if (bus.imem_req_ready) void'(exp_addr_q.pop_front());
                end
            end
            if (bus.instr_valid) begin
                if (exp_q.size() == 0) chk("exp_q_nonempty", 32'd0, 32'd1);
                else begin
                    chk("pc", bus.pc, exp_q[0][63:32]);
                    chk("instr", bus.instr, exp_q[0][31:0]);
                    chk("pc_plus4", bus.pc_plus4, exp_q[0][63:32] + 32'd4);
                    if (bus.instr_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("instr_nop", bus.instr, NOP);
            end
        end else begin
            exp_valid_next = 1'b0;
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        areset = 1'b1;
        rsp_real = 1'b0;
        // A response arriving in the reset cycle must lose to reset.
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = $urandom();
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        exp_addr_q.delete();
        exp_q.delete();
        model_pc = RST_PC;
        exp_addr_q.push_back(RST_PC);
        pending = 1'b0; holding = 1'b0; acc_seen = 1'b0; ret_seen = 1'b0;
        hold_cycles = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_instr", bus.instr, NOP);
        chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_state", {30'd0, state}, {30'd0, S_REQ});
        chk("rst_pc_plus4", bus.pc_plus4, RST_PC + 32'd4);
    endtask

    task automatic drive_cycle(input int cyc);
        @(posedge clk); #1;
        mon_en = 1'b1;
        if (ret_seen) begin
            if (dir_q.size() > 0) begin
                model_pc = dir_q[0].exp_next;
                void'(dir_q.pop_front());
            end else begin
                model_pc = ret_pcsrc ? ((model_pc + ret_imm) & 32'hFFFF_FFFC) : (model_pc + 32'd4);
            end
            exp_addr_q.push_back(model_pc);
            holding = 1'b0;
            hold_cycles = 0;
            n_retired++;
        end
        if (rsp_real) holding = 1'b1;
        if (acc_seen) begin
            pending  = 1'b1;
            rsp_wait = $urandom_range(0, 2);
        end

        rsp_real = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom();
        if (pending) begin
            if (rsp_wait == 0) begin
                rsp_real = 1'b1;
                bus.imem_rsp_valid = 1'b1;
                exp_q.push_back({model_pc, bus.imem_rsp_data});
                pending = 1'b0;
            end else begin
                rsp_wait--;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            bus.imem_rsp_valid = 1'b1;
        end

        bus.imem_req_ready = (cyc < 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (holding) hold_cycles++;
        bus.instr_ready = ($urandom_range(0, 2) == 0) && !(n_retired == 0 && hold_cycles <= 5);
        if (holding && bus.instr_ready && dir_q.size() > 0) begin
            bus.PCSRC   = dir_q[0].pcsrc;
            bus.imm_ext = dir_q[0].imm;
        end else begin
            bus.PCSRC   = 1'($urandom_range(0, 1));
            bus.imm_ext = $urandom();
        end

        @(negedge clk);
        acc_seen  = !pending && !holding && !rsp_real && bus.imem_req_ready;
        ret_seen  = holding && bus.instr_ready;
        ret_pcsrc = bus.PCSRC;
        ret_imm   = bus.imm_ext;
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.PCSRC          = 1'b0;
        bus.imm_ext        = '0;
        n_retired = 0;
        dir_q.push_back('{1'b1, 32'h0000_0010, 32'h0000_0010});
        dir_q.push_back('{1'b0, 32'hDEAD_BEE0, 32'h0000_0014});
        dir_q.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0000_0010});
        dir_q.push_back('{1'b1, 32'hFFFF_FFF8, 32'h0000_0008});
        dir_q.push_back('{1'b1, 32'hFFFF_FFF4, 32'hFFFF_FFFC});
        dir_q.push_back('{1'b0, 32'h1234_5678, 32'h0000_0000});
        dir_q.push_back('{1'b1, 32'h0000_0100, 32'h0000_0100});
        dir_q.push_back('{1'b1, 32'h0000_0006, 32'h0000_0104});

        repeat (2) @(posedge clk);
        do_reset();
        for (int c = 0; c < 2000; c++) drive_cycle(c);
        chk("directed_done", dir_q.size(), 32'd0);

        // Reset while a fetch is in flight
        begin
            int tries;
            tries = 0;
            while (!pending && tries < 50) begin
                drive_cycle(100);
                tries++;
            end
            chk("reached_wait", {31'd0, pending}, 32'd1);
            chk("in_wait_state", {30'd0, state}, {30'd0, S_WAIT});
        end
        do_reset();
        for (int c = 0; c < 500; c++) drive_cycle(c);
        chk("retired_enough", {31'd0, n_retired > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
